trace_ingress_sink: RTL
=======================

# trace_ingress_sink

Consumer end of the two-lane instruction-trace bundle broadcast by the core's trace nexus. Captures up to two retired-instruction records per cycle (lane 0 older than lane 1), buffers them in program order in a FIFO, and drains them one per cycle over a valid/ready stream to the downstream trace encoder. On overflow, it drops whole cycles atomically and flags the loss on the next record delivered.

## Interface
- DEPTH, default 8: FIFO entries; power of two, ≥4.
- CNT_W, default 16: width of the saturating drop counter.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_0_valid / in_1_valid  in  1  lane retire-valid; lane 0 is older.
- in_N_iaddr  in  40  instruction address.
- in_N_insn  in  32  instruction word.
- in_N_priv  in  3  privilege level.
- in_N_exception, in_N_interrupt  in  1  trap flags.
- in_N_cause  in  64  trap cause.
- in_N_tval  in  40  trap value.
- out_valid  out  1  head record available.
- out_ready  in  1  downstream accepts the head record.
- out_iaddr, out_insn, out_priv, out_exception, out_interrupt, out_cause, out_tval  out  40/32/3/1/1/64/40  head record payload.
- out_lane  out  1  source lane of the head record.
- out_lost  out  1  one or more records were dropped immediately before this record.
- drop_count  out  CNT_W  count of dropped cycles, saturating. Present only with TRACE_SINK_STATS_EN.

## Operation
- Entry = payload (181 b) + lane bit + lost bit. Storage, read/write pointers (log2 DEPTH bits, wrap modulo DEPTH), and occupancy count (log2 DEPTH + 1 bits).
- n_in = in_0_valid + in_1_valid, range 0..2.
- Space check uses the count at the start of the cycle. A same-cycle dequeue does not free space for that cycle's enqueue.
- If n_in ≤ DEPTH − count:
  - Write valid lanes in order: lane 0 at wptr, then lane 1 at wptr+1. If only lane 1 is valid, it goes at wptr.
  - wptr += n_in.
- Otherwise drop both lanes atomically. Never enqueue lane 0 alone on overflow.
  - Set lost_pend.
  - If TRACE_SINK_STATS_EN is defined, drop_count += 1, saturating at all-ones.
- The first record enqueued while lost_pend=1 is stored with lost=1. lost_pend clears in that same cycle, unless that same cycle also overflows, which cannot happen because enqueue and drop are exclusive.
- Dequeue when out_valid && out_ready: rptr += 1.
- Next count = count + enq − deq, where enq ∈ {0,1,2} and deq ∈ {0,1}. Simultaneous enqueue and dequeue is legal at any occupancy.
- out_valid = (count != 0). Payload, out_lane, and out_lost come from storage[rptr].
- Payload must hold stable while out_valid && !out_ready.
- n_in = 0: no state change except a dequeue.

## Timing
- Write latency: a record presented at edge N is visible on out_* after edge N, so out_valid rises in cycle N+1 when the FIFO was empty.
- No combinational path from in_* to out_*. out_ready affects only the next-state logic.
- Throughput: 1 record/cycle out, 2 records/cycle in. Sustained dual retire overflows unless the FIFO drains.
- Full (count = DEPTH): any n_in ≥ 1 drops.
- count = DEPTH−1: n_in = 1 is accepted; n_in = 2 drops both lanes.
- Reset (asserted low, at any time, including mid-stream): pointers, count, and lost_pend go to 0. Storage is cleared to 0. out_valid=0; all payload outputs, out_lane, out_lost, and drop_count read 0. Inputs in the deassertion cycle are sampled normally.

## Configuration
- TRACE_SINK_STATS_EN defined: the drop_count port and counter are present, behaving as above.
- TRACE_SINK_STATS_EN undefined: the port and counter are absent. Drop and out_lost behaviour are unchanged.

## Test plan
- Single lane. Reset, then one cycle with in_0_valid=1, iaddr=0x80000000, insn=0x00000013 → next cycle out_valid=1, out_iaddr=0x80000000, out_lane=0, out_lost=0. With out_ready=1 → out_valid=0 the cycle after.
- Ordering. Dual retire, lane0 iaddr=0x100 and lane1 iaddr=0x104, out_ready=1 → output 0x100 (lane 0), then 0x104 (lane 1), on consecutive cycles.
- Lane-1-only. in_1_valid=1 only, cause=0x8000000000000007, interrupt=1 → one record out with out_lane=1 and the same cause and interrupt fields.
- Overflow. DEPTH=8, out_ready=0, 4 dual cycles → count=8. A 5th dual cycle is dropped (drop_count=1). Drain 1, then another dual cycle is dropped (count=7) (drop_count=2). A single retire iaddr=0x200 is accepted. Draining shows eight records, then 0x200 with out_lost=1. All others have out_lost=0.
- Wrap and simultaneity. Keep out_ready=1 with alternating 2/0 retires for 3×DEPTH cycles → every record appears exactly once, in order, and count never exceeds 2.
- Reset mid-stream. Assert reset low with count=5 and lost_pend=1 → out_valid=0 and drop_count=0 immediately. After release, the first record has out_lost=0.

Source files
------------

// File: rtl/trace_ingress_sink_if.sv
// Two-lane retire bundle from the trace nexus plus the drained record stream.
// slave: the sink's view; master: the producer/consumer environment's view.
interface trace_ingress_sink_if;
  logic        in_0_valid;
  logic [39:0] in_0_iaddr;
  logic [31:0] in_0_insn;
  logic [2:0]  in_0_priv;
  logic        in_0_exception;
  logic        in_0_interrupt;
  logic [63:0] in_0_cause;
  logic [39:0] in_0_tval;

  logic        in_1_valid;
  logic [39:0] in_1_iaddr;
  logic [31:0] in_1_insn;
  logic [2:0]  in_1_priv;
  logic        in_1_exception;
  logic        in_1_interrupt;
  logic [63:0] in_1_cause;
  logic [39:0] in_1_tval;

  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_iaddr;
  logic [31:0] out_insn;
  logic [2:0]  out_priv;
  logic        out_exception;
  logic        out_interrupt;
  logic [63:0] out_cause;
  logic [39:0] out_tval;
  logic        out_lane;
  logic        out_lost;

  modport slave (
    input  in_0_valid, in_0_iaddr, in_0_insn, in_0_priv,
           in_0_exception, in_0_interrupt, in_0_cause, in_0_tval,
    input  in_1_valid, in_1_iaddr, in_1_insn, in_1_priv,
           in_1_exception, in_1_interrupt, in_1_cause, in_1_tval,
    input  out_ready,
    output out_valid, out_iaddr, out_insn, out_priv, out_exception,
           out_interrupt, out_cause, out_tval, out_lane, out_lost
  );

  modport master (
    output in_0_valid, in_0_iaddr, in_0_insn, in_0_priv,
           in_0_exception, in_0_interrupt, in_0_cause, in_0_tval,
    output in_1_valid, in_1_iaddr, in_1_insn, in_1_priv,
           in_1_exception, in_1_interrupt, in_1_cause, in_1_tval,
    output out_ready,
    input  out_valid, out_iaddr, out_insn, out_priv, out_exception,
           out_interrupt, out_cause, out_tval, out_lane, out_lost
  );
endinterface

// File: rtl/trace_ingress_sink.sv
// Two-lane trace capture FIFO, 1-cycle write-to-output latency, drains one record per cycle on valid/ready.
// Overflowing cycles are dropped whole and flagged on the next record; TRACE_SINK_STATS_EN adds drop_count.
module trace_ingress_sink #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  trace_ingress_sink_if.slave  bus
`ifdef TRACE_SINK_STATS_EN
  ,
  output logic [CNT_W-1:0]     drop_count
`endif
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [39:0] iaddr;
    logic [31:0] insn;
    logic [2:0]  priv;
    logic        exception;
    logic        interrupt;
    logic [63:0] cause;
    logic [39:0] tval;
  } rec_t;

  typedef struct packed {
    rec_t rec;
    logic lane;
    logic lost;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            lost_pend_q, lost_pend_d;

  rec_t            rec0, rec1;
  entry_t          ent0, ent1, head;
  logic [1:0]      n_in;
  logic [1:0]      enq_n;
  logic [AW:0]     space;
  logic            accept, drop, deq;
  logic            wr0_en, wr1_en;
  logic [AW-1:0]   wr1_ptr;

  assign rec0 = '{iaddr: bus.in_0_iaddr, insn: bus.in_0_insn, priv: bus.in_0_priv,
                  exception: bus.in_0_exception, interrupt: bus.in_0_interrupt,
                  cause: bus.in_0_cause, tval: bus.in_0_tval};
  assign rec1 = '{iaddr: bus.in_1_iaddr, insn: bus.in_1_insn, priv: bus.in_1_priv,
                  exception: bus.in_1_exception, interrupt: bus.in_1_interrupt,
                  cause: bus.in_1_cause, tval: bus.in_1_tval};

  // Space is judged on start-of-cycle occupancy; a same-cycle dequeue does not help.
  assign n_in   = {1'b0, bus.in_0_valid} + {1'b0, bus.in_1_valid};
  assign space  = DEPTH_C - count_q;
  assign accept = (n_in != 2'd0) && ((AW+1)'(n_in) <= space);
  assign drop   = (n_in != 2'd0) && !accept;
  assign enq_n  = accept ? n_in : 2'd0;
  assign deq    = (count_q != '0) && bus.out_ready;

  assign wr0_en  = accept && bus.in_0_valid;
  assign wr1_en  = accept && bus.in_1_valid;
  assign wr1_ptr = wptr_q + AW'(bus.in_0_valid);

  // Only the oldest record written while a loss is pending carries the flag.
  assign ent0 = '{rec: rec0, lane: 1'b0, lost: lost_pend_q};
  assign ent1 = '{rec: rec1, lane: 1'b1, lost: lost_pend_q && !bus.in_0_valid};

  always_comb begin
    wptr_d      = wptr_q + AW'(enq_n);
    rptr_d      = rptr_q + AW'(deq);
    count_d     = count_q + (AW+1)'(enq_n) - (AW+1)'(deq);
    lost_pend_d = lost_pend_q;
    if (drop) begin
      lost_pend_d = 1'b1;
    end else if (accept) begin
      lost_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      lost_pend_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      lost_pend_q <= lost_pend_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_en) begin
        mem_q[wptr_q] <= ent0;
      end
      if (wr1_en) begin
        mem_q[wr1_ptr] <= ent1;
      end
    end
  end

`ifdef TRACE_SINK_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  // Outputs come straight from storage, so nothing on in_* reaches out_* combinationally.
  assign head              = mem_q[rptr_q];
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_iaddr     = head.rec.iaddr;
  assign bus.out_insn      = head.rec.insn;
  assign bus.out_priv      = head.rec.priv;
  assign bus.out_exception = head.rec.exception;
  assign bus.out_interrupt = head.rec.interrupt;
  assign bus.out_cause     = head.rec.cause;
  assign bus.out_tval      = head.rec.tval;
  assign bus.out_lane      = head.lane;
  assign bus.out_lost      = head.lost;

endmodule
